// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and constants for the cacheline arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cacheline_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    // Memory operation; write dominates when a client asserts both.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Arbitration policy selectors.
    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // Resolve a channel's operation from its write strobe (write wins).
    function automatic op_t op_from_write(input logic wr);
        return wr ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection among requesting channels (fixed or round-robin).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; caller decides when a pick is consumed.
module arb_picker
    import cacheline_arbiter_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int PRIO_MODE = PRIO_FIXED
) (
    input  logic [N_CH-1:0]          req,
    input  logic [$clog2(N_CH)-1:0]  last_grant,
    output logic                     grant_valid,
    output logic [$clog2(N_CH)-1:0]  grant_idx
);

    localparam int IDX_W = $clog2(N_CH);

    // Pick the first requester in search order; the search order depends on the mode.
    always_comb begin : p_pick
        logic [IDX_W-1:0] cand_idx;
        int               cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        if (PRIO_MODE == PRIO_RR) begin
            // Start one past the last winner and wrap, so every requester gets a turn.
            for (int k = 1; k <= N_CH; k++) begin
                cand     = (int'(last_grant) + k) % N_CH;
                cand_idx = IDX_W'(cand);
                if (!grant_valid && req[cand_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end else begin
            // Scan downwards so the lowest-index requester is the last to overwrite.
            for (int i = N_CH - 1; i >= 0; i--) begin
                cand_idx = IDX_W'(i);
                if (req[cand_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Multiplexes N cacheline clients onto one memory port, one transaction at a time.
// Latency: grant at t -> mem op from t+1; mem_resp at m -> ch_resp/ch_rdata at m+1.
// Backpressure: requests are only sampled in IDLE; clients hold until their ch_resp.
module cacheline_arbiter
    import cacheline_arbiter_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter int PRIO_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_read,
    input  logic [N_CH-1:0]          ch_write,
    input  logic [N_CH*ADDR_W-1:0]   ch_address,
    input  logic [N_CH*LINE_W-1:0]   ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [N_CH-1:0]          ch_resp,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_resp
);

    localparam int                IDX_W    = $clog2(N_CH);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_CH - 1);

    arb_state_t        state;
    arb_state_t        next_state;
    logic [N_CH-1:0]   req;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  lat_idx;
    logic              grant_fire;
    logic              mem_done;
    op_t               win_op;

    logic [ADDR_W-1:0] addr_arr  [N_CH];
    logic [LINE_W-1:0] wdata_arr [N_CH];

    // Unflatten the per-channel operand buses.
    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign addr_arr[g]  = ch_address[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = ch_wdata[g*LINE_W +: LINE_W];
    end

    assign req    = ch_read | ch_write;
    assign win_op = op_from_write(ch_write[grant_idx]);

    arb_picker #(
        .N_CH      (N_CH),
        .PRIO_MODE (PRIO_MODE)
    ) u_picker (
        .req         (req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the two events that steer the datapath.
    always_comb begin
        next_state = state;
        grant_fire = 1'b0;
        mem_done   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    grant_fire = 1'b1;
                    next_state = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_resp) begin
                    mem_done   = 1'b1;
                    next_state = ARB_DONE;
                end
            end
            ARB_DONE: begin
                next_state = ARB_IDLE;
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    // Registered datapath: latch the winner on grant, the read line on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= LAST_RST;
            lat_idx     <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            ch_resp     <= '0;
            ch_rdata    <= '0;
        end else begin
            // ch_resp is a single-cycle pulse unless re-armed below.
            ch_resp <= '0;
            if (grant_fire) begin
                lat_idx     <= grant_idx;
                last_grant  <= grant_idx;
                mem_address <= addr_arr[grant_idx];
                mem_wdata   <= wdata_arr[grant_idx];
                mem_read    <= (win_op == OP_READ);
                mem_write   <= (win_op == OP_WRITE);
            end
            if (mem_done) begin
                ch_rdata         <= mem_rdata;
                mem_read         <= 1'b0;
                mem_write        <= 1'b0;
                ch_resp[lat_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed self-checking bench: a 2-channel fixed-priority and a 3-channel round-robin arbiter.
// Inputs are driven and outputs sampled on the falling clock edge.
// Memory responses are driven by hand with known latencies.
module tb_cacheline_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Fixed-priority instance, two channels.
    logic [1:0]   f_read, f_write, f_resp;
    logic [63:0]  f_addr;
    logic [511:0] f_wdata;
    logic [255:0] f_rdata, f_mwdata, f_mrdata;
    logic         f_mread, f_mwrite, f_mresp;
    logic [31:0]  f_maddr;

    // Round-robin instance, three channels.
    logic [2:0]   r_read, r_write, r_resp;
    logic [95:0]  r_addr;
    logic [767:0] r_wdata;
    logic [255:0] r_rdata, r_mwdata, r_mrdata;
    logic         r_mread, r_mwrite, r_mresp;
    logic [31:0]  r_maddr;

    cacheline_arbiter #(.N_CH(2), .ADDR_W(32), .LINE_W(256), .PRIO_MODE(0)) dut_fx (
        .clk(clk), .rst(rst),
        .ch_read(f_read), .ch_write(f_write), .ch_address(f_addr), .ch_wdata(f_wdata),
        .ch_rdata(f_rdata), .ch_resp(f_resp),
        .mem_read(f_mread), .mem_write(f_mwrite), .mem_address(f_maddr), .mem_wdata(f_mwdata),
        .mem_rdata(f_mrdata), .mem_resp(f_mresp)
    );

    cacheline_arbiter #(.N_CH(3), .ADDR_W(32), .LINE_W(256), .PRIO_MODE(1)) dut_rr (
        .clk(clk), .rst(rst),
        .ch_read(r_read), .ch_write(r_write), .ch_address(r_addr), .ch_wdata(r_wdata),
        .ch_rdata(r_rdata), .ch_resp(r_resp),
        .mem_read(r_mread), .mem_write(r_mwrite), .mem_address(r_maddr), .mem_wdata(r_mwdata),
        .mem_rdata(r_mrdata), .mem_resp(r_mresp)
    );

    task automatic test_reset();
        f_read = '0; f_write = '0; f_addr = '0; f_wdata = '0; f_mrdata = '0; f_mresp = 1'b0;
        r_read = '0; r_write = '0; r_addr = '0; r_wdata = '0; r_mrdata = '0; r_mresp = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (f_mread !== 1'b0)   begin n_bad++; $display("FAIL rst_mread got %b want 0", f_mread); end
        n_cmp++; if (f_mwrite !== 1'b0)  begin n_bad++; $display("FAIL rst_mwrite got %b want 0", f_mwrite); end
        n_cmp++; if (f_maddr !== 32'h0)  begin n_bad++; $display("FAIL rst_maddr got %h want 0", f_maddr); end
        n_cmp++; if (f_mwdata !== 256'h0) begin n_bad++; $display("FAIL rst_mwdata got %h want 0", f_mwdata); end
        n_cmp++; if (f_resp !== 2'b00)   begin n_bad++; $display("FAIL rst_resp got %b want 00", f_resp); end
        n_cmp++; if (f_rdata !== 256'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", f_rdata); end
        n_cmp++; if ({r_mread, r_mwrite, r_resp} !== 5'b0) begin n_bad++; $display("FAIL rst_rr_outs got %b want 0", {r_mread, r_mwrite, r_resp}); end
    endtask

    // ch1 read of 0x1000, memory answers in the 4th BUSY cycle.
    task automatic test_single_read();
        logic [255:0] line;
        line = {32{8'hA5}};
        f_read = 2'b10;
        f_addr = {32'h0000_1000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (f_mread !== 1'b1)       begin n_bad++; $display("FAIL rd_mread[%0d] got %b want 1", i, f_mread); end
            n_cmp++; if (f_maddr !== 32'h1000)   begin n_bad++; $display("FAIL rd_maddr[%0d] got %h want 1000", i, f_maddr); end
            n_cmp++; if (f_resp !== 2'b00)       begin n_bad++; $display("FAIL rd_early_resp[%0d] got %b want 00", i, f_resp); end
            if (i == 3) begin f_mresp = 1'b1; f_mrdata = line; end
        end
        @(negedge clk);
        f_mresp = 1'b0; f_mrdata = '0;
        n_cmp++; if (f_mread !== 1'b0)  begin n_bad++; $display("FAIL rd_mread_done got %b want 0", f_mread); end
        n_cmp++; if (f_resp !== 2'b10)  begin n_bad++; $display("FAIL rd_resp got %b want 10", f_resp); end
        n_cmp++; if (f_rdata !== line)  begin n_bad++; $display("FAIL rd_rdata got %h want %h", f_rdata, line); end
        f_read = 2'b00;
        @(negedge clk);
        n_cmp++; if (f_resp !== 2'b00)  begin n_bad++; $display("FAIL rd_resp_pulse got %b want 00", f_resp); end
        n_cmp++; if (f_rdata !== line)  begin n_bad++; $display("FAIL rd_rdata_hold got %h want %h", f_rdata, line); end
        @(negedge clk);
    endtask

    // Both channels request together; ch0 first, ch1 next.
    task automatic test_contention();
        f_read = 2'b11;
        f_addr = {32'h0000_0200, 32'h0000_0100};
        @(negedge clk);
        n_cmp++; if (f_maddr !== 32'h100) begin n_bad++; $display("FAIL ct_first_addr got %h want 100", f_maddr); end
        f_mresp = 1'b1; f_mrdata = {8{32'h1111_0000}};
        @(negedge clk);
        f_mresp = 1'b0;
        n_cmp++; if (f_resp !== 2'b01) begin n_bad++; $display("FAIL ct_resp0 got %b want 01", f_resp); end
        f_read = 2'b10;
        @(negedge clk);
        n_cmp++; if (f_mread !== 1'b0) begin n_bad++; $display("FAIL ct_idle_mread got %b want 0", f_mread); end
        @(negedge clk);
        n_cmp++; if (f_maddr !== 32'h200) begin n_bad++; $display("FAIL ct_second_addr got %h want 200", f_maddr); end
        f_mresp = 1'b1; f_mrdata = {8{32'h2222_0000}};
        @(negedge clk);
        f_mresp = 1'b0;
        n_cmp++; if (f_resp !== 2'b10) begin n_bad++; $display("FAIL ct_resp1 got %b want 10", f_resp); end
        n_cmp++; if (f_rdata !== {8{32'h2222_0000}}) begin n_bad++; $display("FAIL ct_rdata1 got %h", f_rdata); end
        f_read = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    // ch0 writes a line to 0x2040; operands must hold through BUSY.
    task automatic test_write();
        logic [255:0] line;
        line = {8{32'hDEAD_BEEF}};
        f_write = 2'b01;
        f_addr  = {32'h0, 32'h0000_2040};
        f_wdata = {256'h0, line};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if ({f_mwrite, f_mread} !== 2'b10) begin n_bad++; $display("FAIL wr_ops[%0d] got %b want 10", i, {f_mwrite, f_mread}); end
            n_cmp++; if (f_maddr !== 32'h2040) begin n_bad++; $display("FAIL wr_maddr[%0d] got %h want 2040", i, f_maddr); end
            n_cmp++; if (f_mwdata !== line)    begin n_bad++; $display("FAIL wr_mwdata[%0d] got %h want %h", i, f_mwdata, line); end
            if (i == 2) f_mresp = 1'b1;
        end
        @(negedge clk);
        f_mresp = 1'b0;
        n_cmp++; if (f_resp !== 2'b01)  begin n_bad++; $display("FAIL wr_resp got %b want 01", f_resp); end
        n_cmp++; if (f_mwrite !== 1'b0) begin n_bad++; $display("FAIL wr_mwrite_done got %b want 0", f_mwrite); end
        f_write = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    // ch1 asserts read and write at once: only a write reaches memory.
    task automatic test_read_write_same();
        f_read  = 2'b10;
        f_write = 2'b10;
        f_addr  = {32'h0000_3000, 32'h0};
        f_wdata = {{8{32'h0BAD_F00D}}, 256'h0};
        @(negedge clk);
        n_cmp++; if ({f_mwrite, f_mread} !== 2'b10) begin n_bad++; $display("FAIL rw_ops got %b want 10", {f_mwrite, f_mread}); end
        n_cmp++; if (f_mwdata !== {8{32'h0BAD_F00D}}) begin n_bad++; $display("FAIL rw_mwdata got %h", f_mwdata); end
        f_mresp = 1'b1;
        @(negedge clk);
        f_mresp = 1'b0;
        n_cmp++; if (f_resp !== 2'b10) begin n_bad++; $display("FAIL rw_resp got %b want 10", f_resp); end
        f_read = 2'b00; f_write = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    // Three channels requesting continuously: 0,1,2,0,1,2 at one txn per 3 cycles, then ch0/ch2 only.
    task automatic test_round_robin();
        int order [8];
        order = '{0, 1, 2, 0, 1, 2, 0, 2};
        r_read = 3'b111;
        r_addr = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
        for (int t = 0; t < 8; t++) begin
            logic [31:0]  exp_addr;
            logic [2:0]   exp_resp;
            logic [255:0] line;
            exp_addr = 32'h10 * (order[t] + 1);
            exp_resp = 3'b001 << order[t];
            line     = {8{32'h5A00_0000 + t}};
            @(negedge clk);
            n_cmp++; if (r_maddr !== exp_addr) begin n_bad++; $display("FAIL rr_addr[%0d] got %h want %h", t, r_maddr, exp_addr); end
            n_cmp++; if (r_mread !== 1'b1)     begin n_bad++; $display("FAIL rr_mread[%0d] got %b want 1", t, r_mread); end
            r_mresp = 1'b1; r_mrdata = line;
            @(negedge clk);
            r_mresp = 1'b0;
            n_cmp++; if (r_resp !== exp_resp) begin n_bad++; $display("FAIL rr_resp[%0d] got %b want %b", t, r_resp, exp_resp); end
            n_cmp++; if (r_rdata !== line)    begin n_bad++; $display("FAIL rr_rdata[%0d] got %h want %h", t, r_rdata, line); end
            if (t == 5) r_read = 3'b101;
            if (t == 7) r_read = 3'b000;
            @(negedge clk);
            n_cmp++; if (r_resp !== 3'b000) begin n_bad++; $display("FAIL rr_idle_resp[%0d] got %b want 000", t, r_resp); end
        end
        @(negedge clk);
    endtask

    // Reset mid-BUSY abandons the transaction; a late mem_resp must be ignored.
    task automatic test_reset_busy();
        f_read = 2'b01;
        f_addr = {32'h0, 32'h0000_4000};
        @(negedge clk);
        n_cmp++; if (f_mread !== 1'b1) begin n_bad++; $display("FAIL rb_busy_mread got %b want 1", f_mread); end
        rst = 1'b1; f_read = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({f_mread, f_mwrite} !== 2'b00) begin n_bad++; $display("FAIL rb_ops got %b want 00", {f_mread, f_mwrite}); end
        n_cmp++; if (f_maddr !== 32'h0)   begin n_bad++; $display("FAIL rb_maddr got %h want 0", f_maddr); end
        n_cmp++; if (f_rdata !== 256'h0)  begin n_bad++; $display("FAIL rb_rdata got %h want 0", f_rdata); end
        n_cmp++; if (f_mwdata !== 256'h0) begin n_bad++; $display("FAIL rb_mwdata got %h want 0", f_mwdata); end
        f_mresp = 1'b1; f_mrdata = {32{8'hEE}};
        @(negedge clk);
        f_mresp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (f_resp !== 2'b00)  begin n_bad++; $display("FAIL rb_stale_resp[%0d] got %b want 00", i, f_resp); end
            n_cmp++; if (f_rdata !== 256'h0) begin n_bad++; $display("FAIL rb_stale_rdata[%0d] got %h want 0", i, f_rdata); end
            n_cmp++; if ({f_mread, f_mwrite} !== 2'b00) begin n_bad++; $display("FAIL rb_stale_ops[%0d] got %b want 00", i, {f_mread, f_mwrite}); end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_read_write_same();
        test_round_robin();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
